exc_pipe: RTL and testbench
===========================

# exc_pipe

Parametrised exception-carrying pipeline register bank for the CPU. It replaces the per-stage single-field exception code registers with one block of `STAGES` registers. Each register carries instruction valid, PC, branch-delay flag and the first (oldest) exception code. Each stage supports per-stage stall, flush, bubble insertion and local exception injection. The last register drives the CP0 exception-commit logic.

## Interface
- `STAGES`, 4, number of pipeline registers (≥2); register 0 is F/D, register `STAGES-1` feeds CP0
- `CODE_W`, 5, exception code width
- `PC_W`, 32, PC width
- `CNT_W`, 16, committed-exception counter width

- `clk`  input  1  clock, rising edge
- `reset`  input  1  asynchronous, active-low reset
- `in_valid`  input  1  instruction entering register 0 is valid
- `in_pc`  input  `PC_W`  PC entering register 0
- `in_bd`  input  1  branch-delay flag entering register 0
- `stall`  input  `STAGES`  bit i holds register i
- `flush`  input  `STAGES`  bit i clears register i to a bubble
- `exc_in_vld`  input  `STAGES`  bit i: stage feeding register i detected an exception
- `exc_in_code`  input  `STAGES*CODE_W`  packed codes; slice i belongs to register i
- `stage_exc`  output  `STAGES`  bit i = register i valid and carrying an exception
- `out_valid`, `out_pc`, `out_bd`  output  1/`PC_W`/1  contents of register `STAGES-1`
- `out_exc`  output  1  register `STAGES-1` carries an exception
- `out_code`  output  `CODE_W`  exception code of register `STAGES-1`; 0 when `out_exc`=0
- `exc_count`  output  `CNT_W`  saturating count of retired exceptions

## Operation
- Each register i holds {valid, pc, bd, exc, code}. The source for register 0 is `in_*` with exc=0. The source for register i>0 is register i-1.
- Update priority per register i on each rising edge, highest first:
  - auto-flush (see Configuration) → bubble
  - `flush[i]` → bubble
  - `stall[i]` → hold
  - i>0 and `stall[i-1]` → bubble
  - otherwise load the source and merge exceptions
- Bubble: valid=0, pc=0, bd=0, exc=0, code=0.
- Merge rule, oldest exception wins:
  - If the source has valid=1 and exc=1, keep its code. `exc_in_vld[i]` is ignored.
  - Else if the source is valid and `exc_in_vld[i]`=1: exc=1, code=`exc_in_code[i]`.
  - Else exc=0, code=0.
  - Exception injection for an invalid source is ignored.
- `stage_exc[i]` = valid_i & exc_i, purely from register state.
- `exc_count` increments when register `STAGES-1` has valid=1, exc=1, and either `stall[STAGES-1]`=0 or auto-flush fires. It saturates at 2^`CNT_W`-1.
- Stall vector is expected monotonic (if `stall[i]` then `stall[j]` for all j<i); the block does not check this.

## Timing
- All outputs are registered. Reset value of every output and every register is 0, applied immediately on `reset` low, independent of `clk`.
- Latency `in_*` → `out_*` is `STAGES` cycles with no stall or flush. Each stall cycle on a register adds one cycle.
- `exc_in_*[i]` is sampled on the edge that loads register i; it is visible on `stage_exc[i]` the next cycle.
- Flush and stall on the same register in the same cycle: flush wins.
- Reset release takes effect at the first rising edge after `reset` goes high. No partial state survives reset mid-operation.

## Configuration
- `EXC_PIPE_AUTO_FLUSH_EN` defined:
  - When register `STAGES-1` holds valid & exc at a rising edge, every register becomes a bubble at that edge, overriding stall and flush.
  - The exception is therefore visible on `out_*` for exactly one cycle.
- Not defined:
  - No automatic flush. Clearing the pipeline is left to the external `flush` vector.
  - The exception stays on `out_*` while `stall[STAGES-1]` is high.

## Test plan
1. Mid-stream reset: load 3 instructions, drive `reset` low between edges → all outputs 0 immediately; `exc_count`=0.
2. Straight flow (`STAGES`=4): `in_valid`=1, `in_pc`=0x00003000 at cycle 0, `exc_in_vld[1]`=1 with code 10 on the edge loading it → cycle 4: `out_valid`=1, `out_pc`=0x00003000, `out_exc`=1, `out_code`=10.
3. Oldest wins: same instruction gets code 4 at register 0 and code 12 at register 2 → `out_code`=4; `stage_exc[2:0]` shows the exception from register 0 onward.
4. Stall: `stall`=4'b0011 for 2 cycles → registers 0 and 1 hold their values; register 2 receives bubbles; `out_valid`=0 two cycles later.
5. Flush+stall on register 1 in the same cycle → register 1 is a bubble next cycle.
6. Auto-flush:
   - With the macro: exception reaches `out_*` with `stall[3]`=1 → next cycle all `stage_exc`=0, `out_valid`=0, `exc_count`=1.
   - Without the macro: the same stimulus holds `out_code` until `stall[3]` drops; `exc_count` becomes 1 on that edge.

Source files
------------

// File: rtl/exc_pipe_if.sv
// exc_pipe_if -- bundle of every non-clock signal of the exception-carrying
// pipeline register bank.
//
// Parameters match exc_pipe: STAGES, CODE_W, PC_W, CNT_W.
//
// Signals
//   in_valid / in_pc / in_bd : instruction entering register 0
//   stall / flush            : per-register hold and clear-to-bubble
//   exc_in_vld / exc_in_code : per-register exception injection (code slice i
//                              is exc_in_code[i*CODE_W +: CODE_W])
//   stage_exc                : per-register "valid and carrying an exception"
//   out_valid/out_pc/out_bd  : contents of the last register
//   out_exc / out_code       : exception state of the last register
//   exc_count                : saturating count of retired exceptions
//
// Modports
//   master : the pipeline control side (drives in_*, stall, flush, exc_in_*)
//   slave  : the register bank itself
interface exc_pipe_if #(
  parameter int STAGES = 4,
  parameter int CODE_W = 5,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
);
  logic                       in_valid;
  logic [PC_W-1:0]            in_pc;
  logic                       in_bd;
  logic [STAGES-1:0]          stall;
  logic [STAGES-1:0]          flush;
  logic [STAGES-1:0]          exc_in_vld;
  logic [STAGES*CODE_W-1:0]   exc_in_code;
  logic [STAGES-1:0]          stage_exc;
  logic                       out_valid;
  logic [PC_W-1:0]            out_pc;
  logic                       out_bd;
  logic                       out_exc;
  logic [CODE_W-1:0]          out_code;
  logic [CNT_W-1:0]           exc_count;

  modport master (
    output in_valid, in_pc, in_bd, stall, flush, exc_in_vld, exc_in_code,
    input  stage_exc, out_valid, out_pc, out_bd, out_exc, out_code, exc_count
  );

  modport slave (
    input  in_valid, in_pc, in_bd, stall, flush, exc_in_vld, exc_in_code,
    output stage_exc, out_valid, out_pc, out_bd, out_exc, out_code, exc_count
  );
endinterface

// File: rtl/exc_pipe.sv
// exc_pipe -- bank of STAGES pipeline registers, each carrying
// {valid, pc, bd, exc, code}. Register 0 is F/D, register STAGES-1 feeds the
// CP0 exception-commit logic. Each register supports stall, flush, bubble
// insertion behind an upstream stall, and local exception injection where the
// oldest exception of an instruction is the one that is kept.
//
// Ports
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, clears every register and counter
//   bus   : exc_pipe_if.slave (see exc_pipe_if.sv for the signal list)
//
// Build option
//   EXC_PIPE_AUTO_FLUSH_EN : when defined, a valid exception sitting in the
//   last register turns every register into a bubble on the next edge,
//   overriding stall and flush. When undefined, clearing the pipe after an
//   exception is left entirely to the external flush vector.
module exc_pipe #(
  parameter int STAGES = 4,
  parameter int CODE_W = 5,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
) (
  input  logic       clk,
  input  logic       reset,
  exc_pipe_if.slave  bus
);

  localparam int LAST = STAGES - 1;

  // register state
  logic [STAGES-1:0]             valid_q;
  logic [STAGES-1:0]             bd_q;
  logic [STAGES-1:0]             exc_q;
  logic [STAGES-1:0][PC_W-1:0]   pc_q;
  logic [STAGES-1:0][CODE_W-1:0] code_q;
  logic [CNT_W-1:0]              count_q;

  // next state
  logic [STAGES-1:0]             valid_d;
  logic [STAGES-1:0]             bd_d;
  logic [STAGES-1:0]             exc_d;
  logic [STAGES-1:0][PC_W-1:0]   pc_d;
  logic [STAGES-1:0][CODE_W-1:0] code_d;

  // per-register source (in_* for register 0, register i-1 otherwise)
  logic [STAGES-1:0]             src_valid;
  logic [STAGES-1:0]             src_bd;
  logic [STAGES-1:0]             src_exc;
  logic [STAGES-1:0][PC_W-1:0]   src_pc;
  logic [STAGES-1:0][CODE_W-1:0] src_code;

  // exception state after merging the source with local injection
  logic [STAGES-1:0]             mrg_exc;
  logic [STAGES-1:0][CODE_W-1:0] mrg_code;

  logic [STAGES-1:0]             stall_up;
  logic                          auto_flush;
  logic                          retire;

`ifdef EXC_PIPE_AUTO_FLUSH_EN
  assign auto_flush = valid_q[LAST] & exc_q[LAST];
`else
  assign auto_flush = 1'b0;
`endif

  // A register whose upstream neighbour is stalled must not copy it, or the
  // held instruction would be duplicated; it takes a bubble instead.
  assign stall_up = {bus.stall[STAGES-2:0], 1'b0};

  always_comb begin
    src_valid[0] = bus.in_valid;
    src_pc[0]    = bus.in_pc;
    src_bd[0]    = bus.in_bd;
    src_exc[0]   = 1'b0;
    src_code[0]  = '0;
    for (int i = 1; i < STAGES; i++) begin
      src_valid[i] = valid_q[i-1];
      src_pc[i]    = pc_q[i-1];
      src_bd[i]    = bd_q[i-1];
      src_exc[i]   = exc_q[i-1];
      src_code[i]  = code_q[i-1];
    end
  end

  // Oldest exception wins: an exception already travelling with the
  // instruction masks any new one. Injection into a bubble is dropped.
  always_comb begin
    mrg_exc  = '0;
    mrg_code = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (src_valid[i] && src_exc[i]) begin
        mrg_exc[i]  = 1'b1;
        mrg_code[i] = src_code[i];
      end else if (src_valid[i] && bus.exc_in_vld[i]) begin
        mrg_exc[i]  = 1'b1;
        mrg_code[i] = bus.exc_in_code[i*CODE_W +: CODE_W];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    bd_d    = bd_q;
    exc_d   = exc_q;
    code_d  = code_q;
    for (int i = 0; i < STAGES; i++) begin
      if (auto_flush || bus.flush[i]) begin
        valid_d[i] = 1'b0;
        pc_d[i]    = '0;
        bd_d[i]    = 1'b0;
        exc_d[i]   = 1'b0;
        code_d[i]  = '0;
      end else if (bus.stall[i]) begin
        // hold: defaults above keep the current contents
      end else if (stall_up[i]) begin
        valid_d[i] = 1'b0;
        pc_d[i]    = '0;
        bd_d[i]    = 1'b0;
        exc_d[i]   = 1'b0;
        code_d[i]  = '0;
      end else begin
        valid_d[i] = src_valid[i];
        pc_d[i]    = src_pc[i];
        bd_d[i]    = src_bd[i];
        exc_d[i]   = mrg_exc[i];
        code_d[i]  = mrg_code[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      pc_q    <= '0;
      bd_q    <= '0;
      exc_q   <= '0;
      code_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      bd_q    <= bd_d;
      exc_q   <= exc_d;
      code_q  <= code_d;
    end
  end

  // An exception retires when it leaves the last register: either the last
  // register is not held, or the auto-flush discards it.
  assign retire = valid_q[LAST] & exc_q[LAST] & (~bus.stall[LAST] | auto_flush);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (retire && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign bus.stage_exc = valid_q & exc_q;
  assign bus.out_valid = valid_q[LAST];
  assign bus.out_pc    = pc_q[LAST];
  assign bus.out_bd    = bd_q[LAST];
  assign bus.out_exc   = valid_q[LAST] & exc_q[LAST];
  assign bus.out_code  = (valid_q[LAST] & exc_q[LAST]) ? code_q[LAST] : '0;
  assign bus.exc_count = count_q;

endmodule

// File: tb/tb_exc_pipe.sv
// tb_exc_pipe -- self-checking bench for exc_pipe (STAGES=4). A counter width
// of 4 is used so the saturation boundary is reachable in a short run.
// Build option EXC_PIPE_AUTO_FLUSH_EN selects the matching expectations.
module tb_exc_pipe;

  localparam int S  = 4;
  localparam int CW = 5;
  localparam int PW = 32;
  localparam int NW = 4;
  localparam int OW = S + 1 + PW + 1 + 1 + CW + NW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exc_pipe_if #(.STAGES(S), .CODE_W(CW), .PC_W(PW), .CNT_W(NW)) bus ();
  exc_pipe #(.STAGES(S), .CODE_W(CW), .PC_W(PW), .CNT_W(NW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model: one record per pipeline register plus the counter
  typedef struct {
    logic          valid;
    logic [PW-1:0] pc;
    logic          bd;
    logic          exc;
    logic [CW-1:0] code;
  } stage_t;

  stage_t      m[S];
  int unsigned m_count;
  localparam int unsigned CNT_MAX = (1 << NW) - 1;

  typedef struct {
    logic            v;
    logic [PW-1:0]   pc;
    logic            bd;
    logic [S-1:0]    st;
    logic [S-1:0]    fl;
    logic [S-1:0]    ev;
    logic [S*CW-1:0] ec;
    logic [S-1:0]    x_se;
    logic            x_ov;
    logic [PW-1:0]   x_pc;
    logic            x_bd;
    logic            x_oe;
    logic [CW-1:0]   x_oc;
    logic [NW-1:0]   x_cnt;
  } vec_t;

  vec_t vecs[10];

  function automatic stage_t bubble();
    stage_t b;
    b.valid = 1'b0; b.pc = '0; b.bd = 1'b0; b.exc = 1'b0; b.code = '0;
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < S; i++) m[i] = bubble();
    m_count = 0;
  endtask

  task automatic model_step(input logic v, input logic [PW-1:0] pc, input logic bd,
                            input logic [S-1:0] st, input logic [S-1:0] fl,
                            input logic [S-1:0] ev, input logic [S*CW-1:0] ec);
    stage_t nx[S];
    stage_t src;
    logic   af;
    logic   head_exc;
    head_exc = m[S-1].valid && m[S-1].exc;
`ifdef EXC_PIPE_AUTO_FLUSH_EN
    af = head_exc;
`else
    af = 1'b0;
`endif
    if (head_exc && (!st[S-1] || af) && m_count < CNT_MAX) m_count++;
    for (int i = 0; i < S; i++) begin
      if (i == 0) begin
        src.valid = v; src.pc = pc; src.bd = bd; src.exc = 1'b0; src.code = '0;
      end else begin
        src = m[i-1];
      end
      if (af || fl[i])                 nx[i] = bubble();
      else if (st[i])                  nx[i] = m[i];
      else if (i > 0 && st[i-1])       nx[i] = bubble();
      else begin
        nx[i] = src;
        if (!(src.valid && src.exc)) begin
          if (src.valid && ev[i]) begin
            nx[i].exc  = 1'b1;
            nx[i].code = ec[i*CW +: CW];
          end else begin
            nx[i].exc  = 1'b0;
            nx[i].code = '0;
          end
        end
      end
    end
    for (int i = 0; i < S; i++) m[i] = nx[i];
  endtask

  function automatic logic [OW-1:0] dut_pack();
    return {bus.stage_exc, bus.out_valid, bus.out_pc, bus.out_bd,
            bus.out_exc, bus.out_code, bus.exc_count};
  endfunction

  function automatic logic [OW-1:0] model_pack();
    logic [S-1:0] se;
    logic         oe;
    for (int i = 0; i < S; i++) se[i] = m[i].valid && m[i].exc;
    oe = m[S-1].valid && m[S-1].exc;
    return {se, m[S-1].valid, m[S-1].pc, m[S-1].bd, oe,
            oe ? m[S-1].code : {CW{1'b0}}, NW'(m_count)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    chk(name, 64'(dut_pack()), 64'(model_pack()));
  endtask

  // Apply one cycle of inputs, advance the model, and return 1 ns after the
  // edge so outputs are sampled well away from it.
  task automatic drive(input logic v, input logic [PW-1:0] pc, input logic bd,
                       input logic [S-1:0] st, input logic [S-1:0] fl,
                       input logic [S-1:0] ev, input logic [S*CW-1:0] ec);
    bus.in_valid    = v;
    bus.in_pc       = pc;
    bus.in_bd       = bd;
    bus.stall       = st;
    bus.flush       = fl;
    bus.exc_in_vld  = ev;
    bus.exc_in_code = ec;
    model_step(v, pc, bd, st, fl, ev, ec);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, '0, '0, '0);
  endtask

  logic [S-1:0]    r_st;
  logic [S-1:0]    r_fl;
  int unsigned     base;

  initial begin
    // straight flow: code 10 injected at register 1, then oldest-wins with
    // code 4 at register 0 masking later injections
    //            v     pc           bd    st    fl    ev       ec          se       ov    pc           bd    oe    oc     cnt
    vecs[0] = '{1'b1, 32'h00003000, 1'b0, 4'h0, 4'h0, 4'b0000, 20'h00000, 4'b0000, 1'b0, 32'h0,       1'b0, 1'b0, 5'd0,  4'd0};
    vecs[1] = '{1'b0, 32'h0,        1'b0, 4'h0, 4'h0, 4'b0010, 20'h00140, 4'b0010, 1'b0, 32'h0,       1'b0, 1'b0, 5'd0,  4'd0};
    vecs[2] = '{1'b0, 32'h0,        1'b0, 4'h0, 4'h0, 4'b0000, 20'h00000, 4'b0100, 1'b0, 32'h0,       1'b0, 1'b0, 5'd0,  4'd0};
    vecs[3] = '{1'b0, 32'h0,        1'b0, 4'h0, 4'h0, 4'b0000, 20'h00000, 4'b1000, 1'b1, 32'h00003000, 1'b0, 1'b1, 5'd10, 4'd0};
    vecs[4] = '{1'b0, 32'h0,        1'b0, 4'h0, 4'h0, 4'b0000, 20'h00000, 4'b0000, 1'b0, 32'h0,       1'b0, 1'b0, 5'd0,  4'd1};
    vecs[5] = '{1'b1, 32'h00004000, 1'b1, 4'h0, 4'h0, 4'b0001, 20'h00004, 4'b0001, 1'b0, 32'h0,       1'b0, 1'b0, 5'd0,  4'd1};
    vecs[6] = '{1'b0, 32'h0,        1'b0, 4'h0, 4'h0, 4'b0111, 20'h030E9, 4'b0010, 1'b0, 32'h0,       1'b0, 1'b0, 5'd0,  4'd1};
    vecs[7] = '{1'b0, 32'h0,        1'b0, 4'h0, 4'h0, 4'b0110, 20'h030E0, 4'b0100, 1'b0, 32'h0,       1'b0, 1'b0, 5'd0,  4'd1};
    vecs[8] = '{1'b0, 32'h0,        1'b0, 4'h0, 4'h0, 4'b0000, 20'h00000, 4'b1000, 1'b1, 32'h00004000, 1'b1, 1'b1, 5'd4,  4'd1};
    vecs[9] = '{1'b0, 32'h0,        1'b0, 4'h0, 4'h0, 4'b0000, 20'h00000, 4'b0000, 1'b0, 32'h0,       1'b0, 1'b0, 5'd0,  4'd2};

    reset           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_pc       = '0;
    bus.in_bd       = 1'b0;
    bus.stall       = '0;
    bus.flush       = '0;
    bus.exc_in_vld  = '0;
    bus.exc_in_code = '0;
    model_reset();
    #1;
    chk("reset_state", 64'(dut_pack()), 64'd0);
    #11;
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].v, vecs[i].pc, vecs[i].bd, vecs[i].st, vecs[i].fl,
            vecs[i].ev, vecs[i].ec);
      chk($sformatf("vec%0d", i), 64'(dut_pack()),
          64'({vecs[i].x_se, vecs[i].x_ov, vecs[i].x_pc, vecs[i].x_bd,
               vecs[i].x_oe, vecs[i].x_oc, vecs[i].x_cnt}));
    end

    // stall 0011 for two cycles: registers 0/1 hold, register 2 gets bubbles
    drive(1'b1, 32'h10, 1'b0, 4'b0000, 4'b0000, 4'b0001, 20'h00003);
    drive(1'b1, 32'h20, 1'b0, 4'b0000, 4'b0000, 4'b0000, 20'h00000);
    chk("stall_pre_se", 64'(bus.stage_exc), 64'(4'b0010));
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 32'h30, 1'b0, 4'b0011, 4'b0000, 4'b0000, 20'h00000);
      chk($sformatf("stall_hold%0d", c), 64'({bus.stage_exc, bus.out_valid}),
          64'({4'b0010, 1'b0}));
    end
    idle();
    chk("stall_rel_se", 64'(bus.stage_exc), 64'(4'b0100));
    idle();
    chk("stall_out_a", 64'({bus.out_valid, bus.out_pc, bus.out_exc, bus.out_code}),
        64'({1'b1, 32'h10, 1'b1, 5'd3}));
    idle();
    chk("stall_out_b", 64'({bus.out_valid, bus.out_pc, bus.out_exc, bus.out_code, bus.exc_count}),
        64'({1'b1, 32'h20, 1'b0, 5'd0, 4'd3}));
    idle();
    check_model("stall_tail");

    // flush and stall on register 1 in the same cycle: flush wins
    drive(1'b1, 32'h40, 1'b0, 4'b0000, 4'b0000, 4'b0001, 20'h00005);
    idle();
    chk("fs_pre_se", 64'(bus.stage_exc), 64'(4'b0010));
    drive(1'b0, 32'h0, 1'b0, 4'b0011, 4'b0010, 4'b0000, 20'h00000);
    chk("fs_se", 64'(bus.stage_exc), 64'(4'b0000));
    for (int c = 0; c < 3; c++) begin
      idle();
      chk($sformatf("fs_drain%0d", c), 64'({bus.out_valid, bus.exc_count}), 64'({1'b0, 4'd3}));
    end

    // exception reaches the last register while it is stalled
    base = m_count;
    drive(1'b1, 32'h50, 1'b0, 4'b0000, 4'b0000, 4'b0001, 20'h00006);
    drive(1'b1, 32'h54, 1'b0, 4'b0000, 4'b0000, 4'b0000, 20'h00000);
    drive(1'b1, 32'h58, 1'b0, 4'b0000, 4'b0000, 4'b0010, 20'h00040);
    idle();
    chk("af_arrive", 64'({bus.stage_exc, bus.out_valid, bus.out_pc, bus.out_exc, bus.out_code}),
        64'({4'b1100, 1'b1, 32'h50, 1'b1, 5'd6}));
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 32'h0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 20'h00000);
`ifdef EXC_PIPE_AUTO_FLUSH_EN
      chk($sformatf("af_stall%0d", c), 64'({bus.stage_exc, bus.out_valid, bus.exc_count}),
          64'({4'b0000, 1'b0, 4'(base + 1)}));
`else
      chk($sformatf("af_stall%0d", c),
          64'({bus.stage_exc, bus.out_valid, bus.out_pc, bus.out_code, bus.exc_count}),
          64'({4'b1100, 1'b1, 32'h50, 5'd6, 4'(base)}));
`endif
    end
    idle();
`ifdef EXC_PIPE_AUTO_FLUSH_EN
    chk("af_release", 64'({bus.out_valid, bus.exc_count}), 64'({1'b0, 4'(base + 1)}));
`else
    chk("af_release", 64'({bus.stage_exc, bus.out_valid, bus.out_pc, bus.out_code, bus.exc_count}),
        64'({4'b1000, 1'b1, 32'h54, 5'd2, 4'(base + 1)}));
`endif
    drive(1'b0, 32'h0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 20'h00000);
    check_model("af_cleanup");

    // randomized traffic with monotonic stall vectors
    for (int c = 0; c < 400; c++) begin
      r_st = '0;
      if ($urandom_range(0, 3) == 0) r_st = S'((1 << $urandom_range(0, S)) - 1);
      r_fl = '0;
      for (int b = 0; b < S; b++) r_fl[b] = ($urandom_range(0, 9) == 0);
      drive(1'($urandom()), $urandom(), 1'($urandom()), r_st, r_fl,
            S'($urandom()), (S*CW)'($urandom()));
      check_model($sformatf("rand%0d", c));
    end

    // saturation of the retired-exception counter
    drive(1'b0, 32'h0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 20'h00000);
    for (int c = 0; c < 24; c++) begin
      drive(1'b1, 32'(c * 4), 1'b0, 4'b0000, 4'b0000, 4'b0001, 20'h0001F);
    end
    chk("sat_count", 64'(bus.exc_count), 64'(4'hF));
    check_model("sat_model");

    // mid-stream reset: everything clears without waiting for a clock edge
    drive(1'b0, 32'h0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 20'h00000);
    drive(1'b1, 32'h100, 1'b1, 4'b0000, 4'b0000, 4'b0001, 20'h00001);
    drive(1'b1, 32'h104, 1'b0, 4'b0000, 4'b0000, 4'b0001, 20'h00002);
    drive(1'b1, 32'h108, 1'b1, 4'b0000, 4'b0000, 4'b0001, 20'h00003);
    chk("mr_loaded_se", 64'(bus.stage_exc), 64'(4'b0111));
    #2;
    reset = 1'b0;
    #1;
    chk("mr_async", 64'(dut_pack()), 64'd0);
    @(posedge clk);
    #1;
    chk("mr_held", 64'(dut_pack()), 64'd0);
    #2;
    reset = 1'b1;
    model_reset();
    idle();
    chk("mr_count", 64'(bus.exc_count), 64'd0);
    check_model("mr_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
